// File: rtl/camera_frame_sequencer.sv
// Drives the OV7670 grabber CI port (base / single-shot trigger / done-poll) and
// rotates three DRAM frame buffers so the consumer always holds a stable pair.
module camera_frame_sequencer #(
  parameter logic [7:0]  customInstructionId = 8'd0,
  parameter logic [7:0]  cameraCiId          = 8'd0,
  parameter int unsigned pollInterval        = 256,
  parameter int unsigned maxPolls            = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ciStart,
  input  logic        ciCke,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  output logic [31:0] ciResult,
  output logic        ciDone,
  output logic        camCiStart,
  output logic        camCiCke,
  output logic [7:0]  camCiN,
  output logic [31:0] camCiValueA,
  output logic [31:0] camCiValueB,
  input  logic [31:0] camCiResult,
  input  logic        camCiDone,
  output logic        frameValid,
  output logic [31:0] currentFrameAddr,
  output logic [31:0] previousFrameAddr,
  input  logic        frameAck
);

  localparam int unsigned TimerW = (pollInterval > 2) ? $clog2(pollInterval) : 1;
  localparam int unsigned CountW = $clog2(maxPolls + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SET_BASE = 3'd1,
    S_TRIGGER  = 3'd2,
    S_POLL     = 3'd3,
    S_CAPTURED = 3'd4,
    S_HOLD     = 3'd5,
    S_ROTATE   = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic                enable_q, enable_d;
  logic [31:0]         base_q [3];
  logic [31:0]         base_d [3];
  logic [1:0]          w_q, w_d, c_q, c_d, p_q, p_d;
  logic                frame_valid_q, frame_valid_d;
  logic                has_prev_q, has_prev_d;
  logic [15:0]         frame_count_q, frame_count_d;
  logic [7:0]          timeout_count_q, timeout_count_d;
  logic [TimerW-1:0]   poll_timer_q, poll_timer_d;
  logic [CountW-1:0]   poll_count_q, poll_count_d;
  logic                cam_start_q, cam_start_d;
  logic [31:0]         cam_a_q, cam_a_d, cam_b_q, cam_b_d;
  logic [31:0]         cur_addr_q, cur_addr_d, prev_addr_q, prev_addr_d;

  logic                is_my_ci;
  logic [2:0]          cmd;
  logic                poll_tick;
  logic                poll_resp;
  logic                in_unused;

  assign in_unused         = ^{camCiResult[31:1], ciValueA[31:3], ciValueB[1]};
  assign camCiStart        = cam_start_q;
  assign camCiCke          = 1'b1;
  assign camCiN            = cameraCiId;
  assign camCiValueA       = cam_a_q;
  assign camCiValueB       = cam_b_q;
  assign frameValid        = frame_valid_q;
  assign currentFrameAddr  = cur_addr_q;
  assign previousFrameAddr = prev_addr_q;

  // CPU CI decode: every command completes in the cycle it is presented
  always_comb begin
    is_my_ci = ciStart & ciCke & (ciN == customInstructionId);
    cmd      = ciValueA[2:0];
    ciDone   = is_my_ci;
    ciResult = '0;
    if (is_my_ci) begin
      case (cmd)
        3'd0:    ciResult = {24'd0, frame_valid_q, has_prev_q, enable_q, 2'b00, state_q};
        3'd5:    ciResult = {16'd0, frame_count_q};
        3'd6:    ciResult = {24'd0, timeout_count_q};
        3'd7:    ciResult = base_q[w_q];
        default: ciResult = '0;
      endcase
    end
  end

  always_comb begin
    state_d         = state_q;
    enable_d        = enable_q;
    base_d          = base_q;
    w_d             = w_q;
    c_d             = c_q;
    p_d             = p_q;
    frame_valid_d   = frame_valid_q;
    has_prev_d      = has_prev_q;
    frame_count_d   = frame_count_q;
    timeout_count_d = timeout_count_q;
    poll_timer_d    = poll_timer_q;
    poll_count_d    = poll_count_q;
    cam_start_d     = 1'b0;
    cam_a_d         = cam_a_q;
    cam_b_d         = cam_b_q;
    cur_addr_d      = cur_addr_q;
    prev_addr_d     = prev_addr_q;
    poll_tick       = (poll_timer_q == TimerW'(pollInterval - 1));
    poll_resp       = cam_start_q & (cam_a_q == 32'd7) & camCiDone;

    if (is_my_ci) begin
      if (cmd == 3'd4) enable_d = ciValueB[0];
      if (state_q == S_IDLE) begin
        case (cmd)
          3'd1:    base_d[0] = {ciValueB[31:2], 2'b00};
          3'd2:    base_d[1] = {ciValueB[31:2], 2'b00};
          3'd3:    base_d[2] = {ciValueB[31:2], 2'b00};
          default: ;
        endcase
      end
    end
    if (frameAck & frame_valid_q) frame_valid_d = 1'b0;

    case (state_q)
      S_IDLE: if (enable_d) state_d = S_SET_BASE;
      S_SET_BASE: begin
        if (!enable_q) state_d = S_IDLE;
        else begin
          cam_start_d = 1'b1;
          cam_a_d     = 32'd5;
          cam_b_d     = base_q[w_q];
          state_d     = S_TRIGGER;
        end
      end
      S_TRIGGER: begin
        cam_start_d  = 1'b1;
        cam_a_d      = 32'd6;
        cam_b_d      = 32'd2;
        poll_timer_d = '0;
        poll_count_d = '0;
        state_d      = S_POLL;
      end
      S_POLL: begin
        poll_timer_d = poll_tick ? '0 : poll_timer_q + TimerW'(1);
        if (!enable_q) state_d = S_IDLE;
        else if (poll_resp && camCiResult[0]) state_d = S_CAPTURED;
        else if (poll_resp && (poll_count_q == CountW'(maxPolls))) begin
          if (timeout_count_q != 8'hFF) timeout_count_d = timeout_count_q + 8'd1;
          state_d = S_SET_BASE;
        end else if (poll_tick) begin
          cam_start_d  = 1'b1;
          cam_a_d      = 32'd7;
          cam_b_d      = 32'd0;
          poll_count_d = poll_count_q + CountW'(1);
        end
      end
      // An ack arriving with the capture lets the rotation proceed directly
      S_CAPTURED: state_d = (!frame_valid_q || frameAck) ? S_ROTATE : S_HOLD;
      S_HOLD: begin
        if (!enable_q) state_d = S_IDLE;
        else if (!frame_valid_q || frameAck) state_d = S_ROTATE;
      end
      S_ROTATE: begin
        p_d           = c_q;
        c_d           = w_q;
        w_d           = p_q;
        cur_addr_d    = base_q[w_q];
        prev_addr_d   = base_q[c_q];
        frame_count_d = frame_count_q + 16'd1;
        if (has_prev_q) frame_valid_d = 1'b1;
        else            has_prev_d    = 1'b1;
        state_d = enable_q ? S_SET_BASE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_d == S_IDLE) && (state_q != S_IDLE)) has_prev_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_IDLE;
      enable_q        <= 1'b0;
      base_q          <= '{default: '0};
      w_q             <= 2'd0;
      c_q             <= 2'd1;
      p_q             <= 2'd2;
      frame_valid_q   <= 1'b0;
      has_prev_q      <= 1'b0;
      frame_count_q   <= '0;
      timeout_count_q <= '0;
      poll_timer_q    <= '0;
      poll_count_q    <= '0;
      cam_start_q     <= 1'b0;
      cam_a_q         <= '0;
      cam_b_q         <= '0;
      cur_addr_q      <= '0;
      prev_addr_q     <= '0;
    end else begin
      state_q         <= state_d;
      enable_q        <= enable_d;
      base_q          <= base_d;
      w_q             <= w_d;
      c_q             <= c_d;
      p_q             <= p_d;
      frame_valid_q   <= frame_valid_d;
      has_prev_q      <= has_prev_d;
      frame_count_q   <= frame_count_d;
      timeout_count_q <= timeout_count_d;
      poll_timer_q    <= poll_timer_d;
      poll_count_q    <= poll_count_d;
      cam_start_q     <= cam_start_d;
      cam_a_q         <= cam_a_d;
      cam_b_q         <= cam_b_d;
      cur_addr_q      <= cur_addr_d;
      prev_addr_q     <= prev_addr_d;
    end
  end

endmodule

// File: tb/tb_camera_frame_sequencer.sv
// Scoreboard bench for camera_frame_sequencer: directed CPU commands and a small
// camera model; expected CPU reads, camera commands and published pairs are queued.
module tb_camera_frame_sequencer;

  localparam logic [7:0] CI_ID  = 8'h11;
  localparam logic [7:0] CAM_ID = 8'h3C;

  logic        clock = 1'b0;
  logic        reset;
  logic        ciStart, ciCke;
  logic [7:0]  ciN;
  logic [31:0] ciValueA, ciValueB, ciResult;
  logic        ciDone;
  logic        camCiStart, camCiCke, camCiDone;
  logic [7:0]  camCiN;
  logic [31:0] camCiValueA, camCiValueB, camCiResult;
  logic        frameValid, frameAck;
  logic [31:0] currentFrameAddr, previousFrameAddr;

  camera_frame_sequencer #(
    .customInstructionId(CI_ID), .cameraCiId(CAM_ID), .pollInterval(4), .maxPolls(4)
  ) dut (
    .clock(clock), .reset(reset), .ciStart(ciStart), .ciCke(ciCke), .ciN(ciN),
    .ciValueA(ciValueA), .ciValueB(ciValueB), .ciResult(ciResult), .ciDone(ciDone),
    .camCiStart(camCiStart), .camCiCke(camCiCke), .camCiN(camCiN),
    .camCiValueA(camCiValueA), .camCiValueB(camCiValueB),
    .camCiResult(camCiResult), .camCiDone(camCiDone),
    .frameValid(frameValid), .currentFrameAddr(currentFrameAddr),
    .previousFrameAddr(previousFrameAddr), .frameAck(frameAck)
  );

  always #5 clock = ~clock;

  // Camera model: answers done on the 2nd poll after each trigger unless never_done
  int unsigned poll_in_trig = 0;
  bit          never_done   = 1'b0;
  logic        cam_ans;
  assign camCiDone   = camCiStart;
  assign cam_ans     = camCiStart && (camCiValueA == 32'd7) && !never_done && (poll_in_trig == 1);
  assign camCiResult = {31'd0, cam_ans};
  always @(posedge clock) begin
    if (camCiStart && camCiValueA == 32'd6) poll_in_trig <= 0;
    else if (camCiStart && camCiValueA == 32'd7) poll_in_trig <= poll_in_trig + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=missing required=event", name);
  endtask

  typedef struct packed { logic [31:0] a; logic [31:0] b; } cam_t;
  typedef struct packed { logic [31:0] cur; logic [31:0] prev; } frm_t;
  cam_t        cam_q[$];
  frm_t        frm_q[$];
  logic [31:0] cpu_q[$];
  bit          cam_sb_en = 1'b0;
  bit          nd_mode   = 1'b0;
  logic [31:0] retrig_base = 32'h1000;
  int unsigned nd_polls = 0;
  int unsigned cam_pulses = 0;
  logic        fv_prev = 1'b0;

  // Monitor: pops expectations whenever the DUT presents a response
  always @(negedge clock) begin
    if (!reset) begin
      if (ciDone && (ciValueA[2:0] inside {3'd0, 3'd5, 3'd6, 3'd7})) begin
        if (cpu_q.size() == 0) fail_now("cpu_unexpected_read");
        else check("cpu_read", ciResult, cpu_q.pop_front());
      end
      if (camCiStart) begin
        cam_pulses++;
        if (camCiValueA == 32'd7) begin
          if (nd_mode) nd_polls++;
        end else if (nd_mode) begin
          if (camCiValueA == 32'd5) check("retrigger_base", camCiValueB, retrig_base);
        end else if (cam_sb_en) begin
          if (cam_q.size() == 0) fail_now("cam_unexpected_cmd");
          else begin
            cam_t e;
            e = cam_q.pop_front();
            check("cam_cmd_a", camCiValueA, e.a);
            check("cam_cmd_b", camCiValueB, e.b);
          end
        end
      end
      if (frameValid && !fv_prev) begin
        if (frm_q.size() == 0) fail_now("frame_unexpected");
        else begin
          frm_t f;
          f = frm_q.pop_front();
          check("frame_current", currentFrameAddr, f.cur);
          check("frame_previous", previousFrameAddr, f.prev);
        end
      end
    end
    fv_prev = frameValid;
  end

  task automatic cpu(input logic [2:0] a, input logic [31:0] b);
    @(posedge clock); #1;
    ciStart = 1'b1; ciCke = 1'b1; ciN = CI_ID; ciValueA = {29'd0, a}; ciValueB = b;
    @(posedge clock); #1;
    ciStart = 1'b0; ciValueA = '0; ciValueB = '0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp);
    cpu_q.push_back(exp);
    cpu(a, 32'd0);
  endtask

  task automatic push_cam(input logic [31:0] a, input logic [31:0] b);
    cam_q.push_back('{a: a, b: b});
  endtask

  task automatic push_frm(input logic [31:0] cur, input logic [31:0] prev);
    frm_q.push_back('{cur: cur, prev: prev});
  endtask

  task automatic pulse_ack();
    @(posedge clock); #1 frameAck = 1'b1;
    @(posedge clock); #1 frameAck = 1'b0;
  endtask

  task automatic wait_frame(input string name, input int lim);
    bit   seen = 1'b0;
    logic last = frameValid;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clock);
      if (frameValid && !last) seen = 1'b1;
      last = frameValid;
    end
    if (!seen) fail_now(name);
  endtask

  task automatic wait_cam(input logic [31:0] a, input logic [31:0] b, input bit any_b,
                          input string name, input int lim);
    bit seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clock);
      if (camCiStart && camCiValueA == a && (any_b || camCiValueB == b)) seen = 1'b1;
    end
    if (!seen) fail_now(name);
  endtask

  task automatic wait_polls(input int unsigned n, input string name, input int lim);
    bit seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clock); #1;
      if (nd_polls >= n) seen = 1'b1;
    end
    if (!seen) fail_now(name);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_camStart"}, {31'd0, camCiStart}, 32'd0);
    check({tag, "_camCke"}, {31'd0, camCiCke}, 32'd1);
    check({tag, "_camN"}, {24'd0, camCiN}, {24'd0, CAM_ID});
    check({tag, "_camA"}, camCiValueA, 32'd0);
    check({tag, "_camB"}, camCiValueB, 32'd0);
    check({tag, "_fv"}, {31'd0, frameValid}, 32'd0);
    check({tag, "_cur"}, currentFrameAddr, 32'd0);
    check({tag, "_prev"}, previousFrameAddr, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned snap;
    int unsigned exp_to;
    reset = 1'b1; ciStart = 1'b0; ciCke = 1'b0; ciN = '0; ciValueA = '0; ciValueB = '0;
    frameAck = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("reset");
    rd(3'd0, 32'd0);
    rd(3'd5, 32'd0);
    rd(3'd6, 32'd0);
    rd(3'd7, 32'd0);

    // Foreign id and missing cke must not be answered
    @(posedge clock); #1 ciStart = 1'b1; ciCke = 1'b1; ciN = 8'h12;
    @(negedge clock);
    check("foreign_id_done", {31'd0, ciDone}, 32'd0);
    check("foreign_id_result", ciResult, 32'd0);
    @(posedge clock); #1 ciCke = 1'b0; ciN = CI_ID;
    @(negedge clock);
    check("no_cke_done", {31'd0, ciDone}, 32'd0);
    @(posedge clock); #1 ciStart = 1'b0;

    cpu(3'd1, 32'h0000_1002);
    cpu(3'd2, 32'h0000_2000);
    cpu(3'd3, 32'h0000_3000);
    rd(3'd7, 32'h0000_1000);

    // Three captures, the third parks in HOLD with the pair held
    cam_sb_en = 1'b1;
    push_cam(5, 32'h1000); push_cam(6, 2);
    push_cam(5, 32'h3000); push_cam(6, 2);
    push_cam(5, 32'h2000); push_cam(6, 2);
    push_frm(32'h3000, 32'h1000);
    cpu(3'd4, 32'd1);
    wait_frame("first_pair_timeout", 200);
    repeat (40) @(negedge clock);
    check("hold_fv", {31'd0, frameValid}, 32'd1);
    check("hold_cur", currentFrameAddr, 32'h3000);
    check("hold_prev", previousFrameAddr, 32'h1000);
    rd(3'd0, 32'h0000_00E5);
    rd(3'd5, 32'd2);
    cpu(3'd2, 32'h0000_5003);
    rd(3'd7, 32'h0000_2000);

    // Ack in HOLD: one-cycle gap then the next pair
    push_frm(32'h2000, 32'h3000);
    push_cam(5, 32'h1000); push_cam(6, 2);
    @(posedge clock); #1 frameAck = 1'b1;
    @(posedge clock); #1 frameAck = 1'b0;
    @(negedge clock);
    check("ack_gap_fv", {31'd0, frameValid}, 32'd0);
    @(negedge clock);
    check("ack_republish_fv", {31'd0, frameValid}, 32'd1);
    repeat (40) @(negedge clock);
    rd(3'd0, 32'h0000_00E5);
    rd(3'd5, 32'd3);

    // Release again, then disable in the first POLL cycles
    push_frm(32'h1000, 32'h2000);
    push_cam(5, 32'h3000); push_cam(6, 2);
    pulse_ack();
    wait_cam(32'd6, 32'd2, 1'b0, "trigger_before_disable", 50);
    cpu(3'd4, 32'd0);
    #1 snap = cam_pulses;
    repeat (20) @(negedge clock);
    #1 check("no_pulse_after_disable", cam_pulses, snap);
    rd(3'd0, 32'h0000_0080);
    check("pending_fv_kept", {31'd0, frameValid}, 32'd1);
    pulse_ack();
    @(negedge clock);
    check("idle_ack_clears_fv", {31'd0, frameValid}, 32'd0);
    rd(3'd0, 32'd0);

    // Base write honoured in IDLE, visible once W reaches buffer 1
    cpu(3'd2, 32'h0000_5003);
    rd(3'd7, 32'h0000_3000);
    push_cam(5, 32'h3000); push_cam(6, 2);
    push_cam(5, 32'h5000); push_cam(6, 2);
    push_frm(32'h5000, 32'h3000);
    cpu(3'd4, 32'd1);
    wait_cam(32'd5, 32'h5000, 1'b0, "w1_base_timeout", 100);
    rd(3'd7, 32'h0000_5000);
    wait_frame("pair_5000_timeout", 200);

    // Camera never done: retrigger the same buffer, timeout count saturates
    nd_mode = 1'b1;
    never_done = 1'b1;
    retrig_base = 32'h1000;
    wait_polls(12, "polls_12_timeout", 400);
    wait_cam(32'd5, 32'd0, 1'b1, "retrigger_timeout", 50);
    exp_to = nd_polls / 4;
    rd(3'd6, exp_to);
    wait_polls(1200, "polls_1200_timeout", 8000);
    wait_cam(32'd5, 32'd0, 1'b1, "retrigger_sat_timeout", 50);
    exp_to = nd_polls / 4;
    if (exp_to > 255) exp_to = 255;
    rd(3'd6, exp_to);
    never_done = 1'b0;
    repeat (80) @(negedge clock);
    rd(3'd0, 32'h0000_00E5);
    rd(3'd5, 32'd6);

    // Reset while parked in HOLD with a published pair
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    nd_mode = 1'b0;
    @(negedge clock);
    check_reset_outputs("hold_reset");
    rd(3'd0, 32'd0);
    rd(3'd5, 32'd0);
    rd(3'd6, 32'd0);
    cpu(3'd1, 32'h0000_A000);
    cpu(3'd2, 32'h0000_B000);
    cpu(3'd3, 32'h0000_C000);
    rd(3'd7, 32'h0000_A000);
    push_cam(5, 32'hA000); push_cam(6, 2);
    cpu(3'd4, 32'd1);
    wait_cam(32'd6, 32'd2, 1'b0, "post_reset_trigger", 50);
    repeat (3) @(negedge clock);

    check("cpu_queue_left", cpu_q.size(), 32'd0);
    check("cam_queue_left", cam_q.size(), 32'd0);
    check("frame_queue_left", frm_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
